rr_mux_arbiter: RTL and testbench
=================================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: bit width of each requester data input and of out_data.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  per-requester request; bit i corresponds to in_i.
REQ-005 in0, in1, in2, in3  input  WIDTH each  requester data; in_i is held stable while req[i]=1 and until grant[i] is seen.
REQ-006 grant  output  4  one-hot, single-cycle acknowledge; grant[i]=1 means in_i was captured this cycle.
REQ-007 select  output  2  index of the requester whose data is currently held in out_data.
REQ-008 out_valid  output  1  out_data holds a transfer not yet accepted.
REQ-009 out_ready  input  1  consumer accepts out_data when out_valid=1 and out_ready=1 at a rising edge.
REQ-010 out_data  output  WIDTH  registered copy of the selected requester's data.
REQ-011 xfer_count  output  8  number of completed output handshakes, modulo 256.

Function
REQ-012 Two states: EMPTY (out_valid=0) and FULL (out_valid=1); out_valid is the registered state bit.
REQ-013 Load condition at each edge: (state=EMPTY) or (state=FULL and out_ready=1), with |req=1.
REQ-014 On load: winner = first i with req[i]=1, scanning circularly from ptr (ptr, ptr+1, ... mod 4); out_data <= in_winner; select <= winner; state -> FULL.
REQ-015 On load, grant is asserted as a registered pulse for exactly the cycle following the capture edge, coincident with the new out_valid/out_data; all other cycles grant=4'b0000.
REQ-016 ptr (2-bit, internal) <= winner+1 mod 4 on every load; ptr wraps from 3 to 0.
REQ-017 FULL, out_ready=1, req=0: state -> EMPTY; out_data and select hold their last values.
REQ-018 FULL, out_ready=0: out_data, select, ptr hold; no grant; req changes are ignored.
REQ-019 EMPTY, req=0: all outputs hold; grant=0.
REQ-020 Back-to-back: with continuous out_ready=1 and pending requests, one transfer per cycle, out_valid held at 1.
REQ-021 Latency: req[i] high before edge t with the block EMPTY -> out_valid=1, out_data=in_i, grant[i]=1 during the cycle after edge t.
REQ-022 xfer_count increments by 1 on every edge with out_valid=1 and out_ready=1; 255 wraps to 0.
REQ-023 A requester granted this cycle does not get priority again until every other requesting line has been served (fairness bound: at most 3 other grants between two grants to a persistently requesting line).
REQ-024 out_ready while out_valid=0 has no effect.

Reset
REQ-025 reset=1 asynchronously forces state=EMPTY, out_valid=0, grant=0, select=0, out_data=0, ptr=0, xfer_count=0, regardless of clk.
REQ-026 Reset asserted mid-transfer discards the held data; no grant and no count increment are produced for it.
REQ-027 First edge after reset deassertion follows REQ-013/014 with ptr=0 (requester 0 has highest priority).

Verification
REQ-028 After reset, req=4'b0100, in2=4'hA, out_ready=1 for one cycle -> next cycle out_valid=1, out_data=4'hA, select=2, grant=4'b0100; following cycle out_valid=0, xfer_count=1.
REQ-029 req=4'b1111 held, out_ready=1, in_i=i -> out_data sequence 0,1,2,3,0 on consecutive cycles, grant 0001,0010,0100,1000,0001.
REQ-030 Stall: load in1=4'h5, out_ready=0 for 5 cycles while req toggles -> out_data stays 4'h5, select=1, grant stays 0; out_ready=1 -> xfer_count+1.
REQ-031 Fairness: req[0] always high, req[3] raised once -> req[3] granted within 2 grants of the request.
REQ-032 Wrap: 256 handshakes -> xfer_count returns to 0; ptr wraps 3->0 observed via grant order.
REQ-033 Assert reset while out_valid=1 between clk edges -> out_valid, out_data, grant, xfer_count read 0 immediately; after release, req=4'b1010 -> grant=4'b0010 first.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin 4:1 request mux feeding a one-entry registered output stage
// Ports: clk, reset (async, active high)
//        req[3:0], in0..in3      requester side; in_i held stable until grant[i]
//        grant[3:0]              one-hot pulse, the cycle after in_i was captured
//        select, out_data        index and data of the held transfer
//        out_valid, out_ready    output handshake
//        xfer_count              completed output handshakes, modulo 256
module rr_mux_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [3:0]       grant,
  output logic [1:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       xfer_count
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t           r_state, w_state_nxt;
  logic [1:0]       r_ptr, r_sel, w_win, w_off;
  logic [7:0]       w_dbl, r_cnt;
  logic [3:0]       w_rot, r_grant;
  logic             w_load, w_take;
  logic [WIDTH-1:0] r_data, w_in;
  assign w_take = (r_state == FULL) && out_ready;
  assign w_load = ((r_state == EMPTY) || out_ready) && (|req);
  // Rotate the request vector so bit 0 is the line at ptr; the lowest set bit
  // of the rotated vector is the winner's offset from ptr.
  assign w_dbl = {req, req} >> r_ptr;
  assign w_rot = w_dbl[3:0];
  assign w_off = w_rot[0] ? 2'd0 : w_rot[1] ? 2'd1 : w_rot[2] ? 2'd2 : 2'd3;
  assign w_win = r_ptr + w_off;
  assign w_in  = (w_win == 2'd0) ? in0 : (w_win == 2'd1) ? in1 : (w_win == 2'd2) ? in2 : in3;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = w_load ? FULL : w_take ? EMPTY : r_state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd0;
      r_grant <= 4'd0;
      r_cnt   <= 8'd0;
    end else begin
      r_grant <= w_load ? (4'd1 << w_win) : 4'd0;
      if (w_take) r_cnt <= r_cnt + 8'd1;
      if (w_load) begin
        r_data <= w_in;
        r_sel  <= w_win;
        r_ptr  <= w_win + 2'd1;
      end
    end
  end
  always_comb begin
    out_valid  = (r_state == FULL);
    out_data   = r_data;
    select     = r_sel;
    grant      = r_grant;
    xfer_count = r_cnt;
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed and randomized checking of rr_mux_arbiter against a behavioural model
module tb_rr_mux_arbiter;
  logic       clk, reset, out_ready, out_valid;
  logic [3:0] req, in0, in1, in2, in3, grant, out_data;
  logic [1:0] select;
  logic [7:0] xfer_count;
  int checks = 0;
  int failures = 0;

  rr_mux_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .req(req),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .grant(grant), .select(select), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .xfer_count(xfer_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
    end
  endtask

  // Reference: first requesting line found by walking ptr, ptr+1, ... mod 4
  function automatic logic [1:0] win(input logic [3:0] r, input logic [1:0] p);
    for (int o = 0; o < 4; o++)
      if (r[(int'(p) + o) % 4]) return 2'((int'(p) + o) % 4);
    return p;
  endfunction

  function automatic logic [3:0] pick(input logic [1:0] w);
    case (w)
      2'd0: return in0;
      2'd1: return in1;
      2'd2: return in2;
      default: return in3;
    endcase
  endfunction

  logic       m_valid;
  logic [3:0] m_data, m_grant;
  logic [1:0] m_sel, m_ptr;
  logic [7:0] m_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 0; m_data <= 0; m_grant <= 0; m_sel <= 0; m_ptr <= 0; m_cnt <= 0;
    end else begin
      if (m_valid && out_ready) m_cnt <= m_cnt + 8'd1;
      if ((!m_valid || out_ready) && req != 4'd0) begin
        m_valid <= 1;
        m_data  <= pick(win(req, m_ptr));
        m_sel   <= win(req, m_ptr);
        m_grant <= 4'd1 << win(req, m_ptr);
        m_ptr   <= win(req, m_ptr) + 2'd1;
      end else begin
        m_grant <= 0;
        if (m_valid && out_ready) m_valid <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_grant", grant, m_grant);
    chk("cmp_valid", out_valid, m_valid);
    chk("cmp_data", out_data, m_data);
    chk("cmp_select", select, m_sel);
    chk("cmp_count", xfer_count, m_cnt);
  end

  task automatic do_reset;
    reset = 1;
    req = 0;
    out_ready = 0;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    reset = 0; req = 0; out_ready = 0;
    in0 = 0; in1 = 0; in2 = 0; in3 = 0;
    #1 reset = 1;
    chk("model_win_a", win(4'b1010, 2'd0), 1);
    chk("model_win_b", win(4'b0001, 2'd1), 0);
    chk("model_win_c", win(4'b1001, 2'd1), 3);
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_grant", grant, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", xfer_count, 0);
    reset = 0;
    // single transfer from requester 2
    req = 4'b0100; in2 = 4'hA; out_ready = 1;
    @(negedge clk);
    chk("one_valid", out_valid, 1);
    chk("one_data", out_data, 4'hA);
    chk("one_select", select, 2);
    chk("one_grant", grant, 4'b0100);
    req = 0;
    @(negedge clk);
    chk("one_drain_valid", out_valid, 0);
    chk("one_drain_count", xfer_count, 1);
    chk("one_drain_grant", grant, 0);
    // all lines requesting: strict rotation
    do_reset;
    in0 = 0; in1 = 1; in2 = 2; in3 = 3; req = 4'b1111; out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rot_data", out_data, k % 4);
      chk("rot_grant", grant, 4'd1 << (k % 4));
      chk("rot_valid", out_valid, 1);
    end
    req = 0;
    @(negedge clk);
    // stall with toggling requests
    do_reset;
    in1 = 4'h5; req = 4'b0010;
    @(negedge clk);
    chk("stall_load_grant", grant, 4'b0010);
    for (int k = 0; k < 5; k++) begin
      req = 4'($urandom);
      in1 = 4'($urandom);
      @(negedge clk);
      chk("stall_data", out_data, 4'h5);
      chk("stall_select", select, 1);
      chk("stall_grant", grant, 0);
      chk("stall_valid", out_valid, 1);
    end
    req = 0; out_ready = 1;
    @(negedge clk);
    chk("stall_count", xfer_count, 1);
    chk("stall_valid_end", out_valid, 0);
    // fairness: line 0 always requesting, line 3 raised once
    do_reset;
    out_ready = 1; req = 4'b0001;
    repeat (3) @(negedge clk);
    chk("fair_pre_grant", grant, 4'b0001);
    req = 4'b1001;
    seen = 0;
    for (int k = 0; k < 2 && !seen; k++) begin
      @(negedge clk);
      if (grant[3]) seen = 1;
    end
    chk("fair_req3_served", seen, 1);
    req = 4'b0001;
    @(negedge clk);
    req = 0;
    @(negedge clk);
    // counter wrap and pointer wrap
    do_reset;
    out_ready = 1; req = 4'b1111;
    for (int k = 1; k <= 257; k++) begin
      @(negedge clk);
      chk("wrap_grant", grant, 4'd1 << ((k - 1) % 4));
    end
    chk("wrap_count", xfer_count, 0);
    req = 0;
    @(negedge clk);
    // asynchronous reset between edges while holding data
    do_reset;
    in0 = 4'h7; req = 4'b0001; out_ready = 0;
    @(negedge clk);
    chk("arst_pre_valid", out_valid, 1);
    chk("arst_pre_grant", grant, 4'b0001);
    #2 reset = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_grant", grant, 0);
    chk("arst_count", xfer_count, 0);
    @(negedge clk);
    reset = 0; req = 4'b1010; out_ready = 1;
    @(negedge clk);
    chk("arst_first_grant", grant, 4'b0010);
    req = 0;
    @(negedge clk);
    // randomized traffic, occasional asynchronous reset
    do_reset;
    for (int k = 0; k < 3000; k++) begin
      req = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      in0 = 4'($urandom); in1 = 4'($urandom); in2 = 4'($urandom); in3 = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1;
        #1 reset = 0;
      end
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
